id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register directly upstream of the ALU. Accepts one decoded instruction
//  per handshake. Holds the instruction for exactly one stage. Drives the ALU operands X/Y
//  and the 4-bit ALU CONTROL. Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
//  Supports stall (valid/ready back-pressure) and flush (branch/jump redirect).
// PARAMETERS
//  XLEN        32   datapath width; X/Y/RESULT width
//  RA_W        5    register address width (x0..x31)
// PORTS
//  CLK            in   1     clock, rising edge
//  RESET_N        in   1     asynchronous reset, active low
//  VALID_IN       in   1     decode stage presents an instruction
//  READY_OUT      out  1     stage can accept this cycle
//  FLUSH          in   1     kill held instruction and incoming one
//  RS1_ADDR       in   RA_W  source 1 register index
//  RS2_ADDR       in   RA_W  source 2 register index
//  RS1_DATA       in   XLEN  register-file read data, source 1
//  RS2_DATA       in   XLEN  register-file read data, source 2
//  IMM            in   XLEN  sign-extended immediate (U-type already in [31:12])
//  PC_IN          in   XLEN  instruction PC
//  SRC_A_SEL      in   2     00 rs1, 01 PC, 10 zero, 11 rs1
//  SRC_B_SEL      in   1     0 rs2, 1 IMM
//  CTRL_IN        in   4     ALU control code (0000 add ... 1110 sra)
//  RD_IN          in   RA_W  destination index
//  REGWRITE_IN    in   1     instruction writes RD_IN
//  EXMEM_REGWRITE in   1     EX/MEM instruction writes back
//  EXMEM_RD       in   RA_W  EX/MEM destination
//  EXMEM_RESULT   in   XLEN  EX/MEM result
//  MEMWB_REGWRITE in   1     MEM/WB instruction writes back
//  MEMWB_RD       in   RA_W  MEM/WB destination
//  MEMWB_RESULT   in   XLEN  MEM/WB write-back data
//  READY_IN       in   1     EX/ALU stage consumes this cycle
//  VALID_OUT      out  1     held instruction valid
//  X              out  XLEN  ALU operand A (combinational from held state + forwarding)
//  Y              out  XLEN  ALU operand B
//  CONTROL        out  4     held ALU control code
//  RD_OUT         out  RA_W  held destination
//  REGWRITE_OUT   out  1     held REGWRITE, forced 0 when VALID_OUT=0
// BEHAVIOUR
//  - Reset (RESET_N=0, async): VALID_OUT=0, all held fields=0.
//    X=Y=0, CONTROL=0000, RD_OUT=0, REGWRITE_OUT=0.
//  - READY_OUT = !VALID_OUT | READY_IN (combinational). Transfer in: VALID_IN & READY_OUT.
//  - Latency: accepted instruction appears on outputs the next cycle.
//    Holds while VALID_OUT & !READY_IN.
//  - Next VALID_OUT: FLUSH -> 0 (dominates; the incoming instruction is not captured).
//    Else transfer in -> 1. Else READY_IN -> 0. Else hold.
//  - Forwarding per source s (rs1, rs2), priority order:
//    1. addr==0 -> 0.
//    2. EXMEM_REGWRITE & EXMEM_RD==addr -> EXMEM_RESULT.
//    3. MEMWB_REGWRITE & MEMWB_RD==addr -> MEMWB_RESULT.
//    4. Otherwise the held data.
//  - Stall refresh: while holding, capture the MEM/WB value into the held rs data each
//    cycle MEMWB_REGWRITE & MEMWB_RD==addr & addr!=0. This keeps values valid after
//    they retire. Never capture EX/MEM values.
//  - X = SRC_A_SEL: rs1_fwd | PC | 0. Y = SRC_B_SEL ? IMM : rs2_fwd. Widths exactly XLEN.
//    No extension beyond XLEN.
//  - Reset mid-stall discards the held instruction; no partial output.
// TESTING
//  1. Reset, then VALID_IN with rs1=x5 (data 7), rs2=x6 (data 3), CTRL=0111, SRC 00/0.
//     Next cycle: VALID_OUT=1, X=7, Y=3, CONTROL=0111.
//  2. Held rs1=x5, EXMEM_RD=5 (RESULT 0x10) and MEMWB_RD=5 (RESULT 0x20), both writing.
//     Expect X=0x10. Drop EX/MEM: expect X=0x20. rs1=x0 with EXMEM_RD=0: X=0.
//  3. READY_IN=0 for 3 cycles, MEMWB writes x6=0x55 in cycle 1 only.
//     READY_OUT=0 throughout. Y=0x55 in cycles 2-3 after MEM/WB clears.
//  4. FLUSH with VALID_IN=1 and READY_OUT=1: next cycle VALID_OUT=0, REGWRITE_OUT=0.
//  5. Back-to-back VALID_IN with READY_IN=1 for 4 cycles: one output per cycle, in order.
//     LUI (SRC_A=10, SRC_B=1, IMM=0x12345000) gives X=0, Y=0x12345000.
//  6. Assert RESET_N=0 asynchronously mid-hold: outputs reach reset values before the next
//     CLK edge.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: holds one decoded instruction, resolves
// RAW hazards by forwarding from EX/MEM and MEM/WB, and selects the X/Y operands.
module id_ex_operand_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            VALID_IN,
    output logic            READY_OUT,
    input  logic            FLUSH,
    input  logic [RA_W-1:0] RS1_ADDR,
    input  logic [RA_W-1:0] RS2_ADDR,
    input  logic [XLEN-1:0] RS1_DATA,
    input  logic [XLEN-1:0] RS2_DATA,
    input  logic [XLEN-1:0] IMM,
    input  logic [XLEN-1:0] PC_IN,
    input  logic [1:0]      SRC_A_SEL,
    input  logic            SRC_B_SEL,
    input  logic [3:0]      CTRL_IN,
    input  logic [RA_W-1:0] RD_IN,
    input  logic            REGWRITE_IN,
    input  logic            EXMEM_REGWRITE,
    input  logic [RA_W-1:0] EXMEM_RD,
    input  logic [XLEN-1:0] EXMEM_RESULT,
    input  logic            MEMWB_REGWRITE,
    input  logic [RA_W-1:0] MEMWB_RD,
    input  logic [XLEN-1:0] MEMWB_RESULT,
    input  logic            READY_IN,
    output logic            VALID_OUT,
    output logic [XLEN-1:0] X,
    output logic [XLEN-1:0] Y,
    output logic [3:0]      CONTROL,
    output logic [RA_W-1:0] RD_OUT,
    output logic            REGWRITE_OUT
);

    logic            valid_q;
    logic [RA_W-1:0] rs1_addr_q;
    logic [RA_W-1:0] rs2_addr_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] pc_q;
    logic [1:0]      src_a_sel_q;
    logic            src_b_sel_q;
    logic [3:0]      ctrl_q;
    logic [RA_W-1:0] rd_q;
    logic            regwrite_q;

    logic            transfer_in;
    logic            hold;
    logic            refresh_rs1;
    logic            refresh_rs2;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    assign READY_OUT   = !valid_q || READY_IN;
    assign transfer_in = VALID_IN && READY_OUT;
    assign hold        = valid_q && !READY_IN;

    // Only MEM/WB is captured while stalled: that value is about to leave the pipe,
    // whereas an EX/MEM producer will still pass through MEM/WB later.
    assign refresh_rs1 = hold && MEMWB_REGWRITE && (MEMWB_RD == rs1_addr_q) && (rs1_addr_q != '0);
    assign refresh_rs2 = hold && MEMWB_REGWRITE && (MEMWB_RD == rs2_addr_q) && (rs2_addr_q != '0);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q     <= 1'b0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            src_a_sel_q <= '0;
            src_b_sel_q <= 1'b0;
            ctrl_q      <= '0;
            rd_q        <= '0;
            regwrite_q  <= 1'b0;
        end else if (FLUSH) begin
            valid_q <= 1'b0;
        end else if (transfer_in) begin
            valid_q     <= 1'b1;
            rs1_addr_q  <= RS1_ADDR;
            rs2_addr_q  <= RS2_ADDR;
            rs1_data_q  <= RS1_DATA;
            rs2_data_q  <= RS2_DATA;
            imm_q       <= IMM;
            pc_q        <= PC_IN;
            src_a_sel_q <= SRC_A_SEL;
            src_b_sel_q <= SRC_B_SEL;
            ctrl_q      <= CTRL_IN;
            rd_q        <= RD_IN;
            regwrite_q  <= REGWRITE_IN;
        end else if (READY_IN) begin
            valid_q <= 1'b0;
        end else begin
            if (refresh_rs1) rs1_data_q <= MEMWB_RESULT;
            if (refresh_rs2) rs2_data_q <= MEMWB_RESULT;
        end
    end

    always_comb begin
        rs1_fwd = rs1_data_q;
        if (rs1_addr_q == '0)
            rs1_fwd = '0;
        else if (EXMEM_REGWRITE && (EXMEM_RD == rs1_addr_q))
            rs1_fwd = EXMEM_RESULT;
        else if (MEMWB_REGWRITE && (MEMWB_RD == rs1_addr_q))
            rs1_fwd = MEMWB_RESULT;
    end

    always_comb begin
        rs2_fwd = rs2_data_q;
        if (rs2_addr_q == '0)
            rs2_fwd = '0;
        else if (EXMEM_REGWRITE && (EXMEM_RD == rs2_addr_q))
            rs2_fwd = EXMEM_RESULT;
        else if (MEMWB_REGWRITE && (MEMWB_RD == rs2_addr_q))
            rs2_fwd = MEMWB_RESULT;
    end

    always_comb begin
        X = rs1_fwd;
        case (src_a_sel_q)
            2'b01:   X = pc_q;
            2'b10:   X = '0;
            default: X = rs1_fwd;
        endcase
        Y = src_b_sel_q ? imm_q : rs2_fwd;
    end

    assign VALID_OUT    = valid_q;
    assign CONTROL      = ctrl_q;
    assign RD_OUT       = rd_q;
    assign REGWRITE_OUT = valid_q && regwrite_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed table of forwarding cases, hand-written
// stall/flush/reset sequences, then random traffic against a reference model.
module tb_id_ex_operand_stage;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        VALID_IN;
    logic        READY_OUT;
    logic        FLUSH;
    logic [4:0]  RS1_ADDR, RS2_ADDR;
    logic [31:0] RS1_DATA, RS2_DATA, IMM, PC_IN;
    logic [1:0]  SRC_A_SEL;
    logic        SRC_B_SEL;
    logic [3:0]  CTRL_IN;
    logic [4:0]  RD_IN;
    logic        REGWRITE_IN;
    logic        EXMEM_REGWRITE;
    logic [4:0]  EXMEM_RD;
    logic [31:0] EXMEM_RESULT;
    logic        MEMWB_REGWRITE;
    logic [4:0]  MEMWB_RD;
    logic [31:0] MEMWB_RESULT;
    logic        READY_IN;
    logic        VALID_OUT;
    logic [31:0] X, Y;
    logic [3:0]  CONTROL;
    logic [4:0]  RD_OUT;
    logic        REGWRITE_OUT;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    id_ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .VALID_IN(VALID_IN), .READY_OUT(READY_OUT),
        .FLUSH(FLUSH), .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
        .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .IMM(IMM), .PC_IN(PC_IN),
        .SRC_A_SEL(SRC_A_SEL), .SRC_B_SEL(SRC_B_SEL), .CTRL_IN(CTRL_IN),
        .RD_IN(RD_IN), .REGWRITE_IN(REGWRITE_IN),
        .EXMEM_REGWRITE(EXMEM_REGWRITE), .EXMEM_RD(EXMEM_RD), .EXMEM_RESULT(EXMEM_RESULT),
        .MEMWB_REGWRITE(MEMWB_REGWRITE), .MEMWB_RD(MEMWB_RD), .MEMWB_RESULT(MEMWB_RESULT),
        .READY_IN(READY_IN), .VALID_OUT(VALID_OUT), .X(X), .Y(Y), .CONTROL(CONTROL),
        .RD_OUT(RD_OUT), .REGWRITE_OUT(REGWRITE_OUT)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] d1, d2, imm, pc;
        logic [1:0]  asel;
        logic        bsel;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
    } instr_t;

    typedef struct {
        logic        ex_we;
        logic [4:0]  ex_rd;
        logic [31:0] ex_res;
        logic        mw_we;
        logic [4:0]  mw_rd;
        logic [31:0] mw_res;
        logic [31:0] exp_x, exp_y;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_instr(input instr_t i);
        RS1_ADDR = i.rs1; RS2_ADDR = i.rs2; RS1_DATA = i.d1; RS2_DATA = i.d2;
        IMM = i.imm; PC_IN = i.pc; SRC_A_SEL = i.asel; SRC_B_SEL = i.bsel;
        CTRL_IN = i.ctrl; RD_IN = i.rd; REGWRITE_IN = i.we;
    endtask

    task automatic clear_fwd();
        EXMEM_REGWRITE = 1'b0; EXMEM_RD = '0; EXMEM_RESULT = '0;
        MEMWB_REGWRITE = 1'b0; MEMWB_RD = '0; MEMWB_RESULT = '0;
    endtask

    // Value a consumer of register 'addr' should see: x0 is zero, otherwise the
    // youngest in-flight producer wins over older ones and over the captured read.
    function automatic logic [31:0] src_val(input logic [4:0] addr, input logic [31:0] captured);
        if (addr == 5'd0) return 32'd0;
        if (EXMEM_REGWRITE && EXMEM_RD == addr) return EXMEM_RESULT;
        if (MEMWB_REGWRITE && MEMWB_RD == addr) return MEMWB_RESULT;
        return captured;
    endfunction

    function automatic logic [31:0] exp_x(input instr_t i);
        if (i.asel == 2'b01) return i.pc;
        if (i.asel == 2'b10) return 32'd0;
        return src_val(i.rs1, i.d1);
    endfunction

    function automatic logic [31:0] exp_y(input instr_t i);
        return i.bsel ? i.imm : src_val(i.rs2, i.d2);
    endfunction

    vec_t   vecs[6];
    instr_t seq[4];
    instr_t t1, tz, ta, tb, rnd, m;
    logic   mvalid;

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'h10, 1'b1, 5'd5, 32'h20, 32'h10, 32'h3};
        vecs[1] = '{1'b0, 5'd5, 32'h10, 1'b1, 5'd5, 32'h20, 32'h20, 32'h3};
        vecs[2] = '{1'b1, 5'd6, 32'h44, 1'b1, 5'd5, 32'h20, 32'h20, 32'h44};
        vecs[3] = '{1'b1, 5'd7, 32'h99, 1'b1, 5'd6, 32'h66, 32'h7,  32'h66};
        vecs[4] = '{1'b0, 5'd5, 32'h10, 1'b0, 5'd6, 32'h20, 32'h7,  32'h3};
        vecs[5] = '{1'b1, 5'd6, 32'h11, 1'b1, 5'd6, 32'h22, 32'h7,  32'h11};

        t1 = '{5'd5, 5'd6, 32'd7, 32'd3, 32'h100, 32'h400, 2'b00, 1'b0, 4'b0111, 5'd9, 1'b1};
        tz = '{5'd0, 5'd0, 32'hdead, 32'hbeef, 32'h0, 32'h0, 2'b00, 1'b0, 4'b0001, 5'd3, 1'b1};
        ta = '{5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 32'h8, 2'b00, 1'b0, 4'b0010, 5'd4, 1'b1};
        tb = '{5'd3, 5'd4, 32'h3, 32'h4, 32'h0, 32'hc, 2'b00, 1'b0, 4'b0011, 5'd5, 1'b1};
        seq[0] = '{5'd1, 5'd2, 32'h11, 32'h22, 32'h5, 32'h100, 2'b00, 1'b0, 4'b0000, 5'd1, 1'b1};
        seq[1] = '{5'd3, 5'd4, 32'h33, 32'h44, 32'hfffffff0, 32'h104, 2'b01, 1'b1, 4'b0001, 5'd2, 1'b0};
        seq[2] = '{5'd5, 5'd6, 32'h55, 32'h66, 32'h7, 32'h108, 2'b11, 1'b0, 4'b1110, 5'd3, 1'b1};
        seq[3] = '{5'd0, 5'd0, 32'h0, 32'h0, 32'h12345000, 32'h10c, 2'b10, 1'b1, 4'b0000, 5'd4, 1'b1};

        RESET_N = 1'b0; VALID_IN = 1'b0; FLUSH = 1'b0; READY_IN = 1'b0;
        drive_instr(t1); clear_fwd();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_valid", {31'd0, VALID_OUT}, 32'd0);
        check("reset_ready", {31'd0, READY_OUT}, 32'd1);
        check("reset_x", X, 32'd0);
        check("reset_y", Y, 32'd0);
        check("reset_ctrl", {28'd0, CONTROL}, 32'd0);
        check("reset_rd", {27'd0, RD_OUT}, 32'd0);
        check("reset_regwrite", {31'd0, REGWRITE_OUT}, 32'd0);
        RESET_N = 1'b1;

        // Capture with a one-cycle latency; stall so the instruction stays held.
        VALID_IN = 1'b1;
        @(posedge CLK); #1;
        VALID_IN = 1'b0; RS1_DATA = 32'hbad0; RS2_DATA = 32'hbad1;
        #2;
        check("t1_valid", {31'd0, VALID_OUT}, 32'd1);
        check("t1_x", X, 32'd7);
        check("t1_y", Y, 32'd3);
        check("t1_ctrl", {28'd0, CONTROL}, 32'h7);
        check("t1_rd", {27'd0, RD_OUT}, 32'd9);
        check("t1_regwrite", {31'd0, REGWRITE_OUT}, 32'd1);
        check("t1_ready", {31'd0, READY_OUT}, 32'd0);

        // Forwarding table; bypass inputs are cleared before each edge so no refresh occurs.
        for (int unsigned k = 0; k < 6; k++) begin
            @(posedge CLK); #1;
            EXMEM_REGWRITE = vecs[k].ex_we; EXMEM_RD = vecs[k].ex_rd; EXMEM_RESULT = vecs[k].ex_res;
            MEMWB_REGWRITE = vecs[k].mw_we; MEMWB_RD = vecs[k].mw_rd; MEMWB_RESULT = vecs[k].mw_res;
            #2;
            check($sformatf("fwd%0d_x", k), X, vecs[k].exp_x);
            check($sformatf("fwd%0d_y", k), Y, vecs[k].exp_y);
            #2;
            clear_fwd();
        end

        // Stall refresh: MEM/WB write to x6 in the first stalled cycle only.
        @(posedge CLK); #1;
        MEMWB_REGWRITE = 1'b1; MEMWB_RD = 5'd6; MEMWB_RESULT = 32'h55;
        #2;
        check("stall_c1_ready", {31'd0, READY_OUT}, 32'd0);
        check("stall_c1_y", Y, 32'h55);
        for (int unsigned c = 2; c <= 3; c++) begin
            @(posedge CLK); #1;
            clear_fwd();
            #2;
            check($sformatf("stall_c%0d_ready", c), {31'd0, READY_OUT}, 32'd0);
            check($sformatf("stall_c%0d_valid", c), {31'd0, VALID_OUT}, 32'd1);
            check($sformatf("stall_c%0d_y", c), Y, 32'h55);
            check($sformatf("stall_c%0d_x", c), X, 32'd7);
        end

        // Asynchronous reset in the middle of a hold, checked before the next edge.
        @(posedge CLK); #2;
        RESET_N = 1'b0;
        #1;
        check("areset_valid", {31'd0, VALID_OUT}, 32'd0);
        check("areset_x", X, 32'd0);
        check("areset_y", Y, 32'd0);
        check("areset_ctrl", {28'd0, CONTROL}, 32'd0);
        check("areset_rd", {27'd0, RD_OUT}, 32'd0);
        check("areset_regwrite", {31'd0, REGWRITE_OUT}, 32'd0);
        #1;
        RESET_N = 1'b1;

        // x0 sources read as zero even with bypass producers targeting x0.
        @(posedge CLK); #1;
        drive_instr(tz); VALID_IN = 1'b1;
        @(posedge CLK); #1;
        VALID_IN = 1'b0;
        EXMEM_REGWRITE = 1'b1; EXMEM_RD = 5'd0; EXMEM_RESULT = 32'h99;
        MEMWB_REGWRITE = 1'b1; MEMWB_RD = 5'd0; MEMWB_RESULT = 32'h77;
        #2;
        check("x0_x", X, 32'd0);
        check("x0_y", Y, 32'd0);
        #2;
        clear_fwd();

        // Flush dominates an accepted transfer.
        @(posedge CLK); #1;
        drive_instr(ta); VALID_IN = 1'b1; READY_IN = 1'b1;
        @(posedge CLK); #1;
        drive_instr(tb); FLUSH = 1'b1;
        #2;
        check("flush_pre_valid", {31'd0, VALID_OUT}, 32'd1);
        check("flush_pre_ready", {31'd0, READY_OUT}, 32'd1);
        @(posedge CLK); #1;
        FLUSH = 1'b0; VALID_IN = 1'b0;
        #2;
        check("flush_valid", {31'd0, VALID_OUT}, 32'd0);
        check("flush_regwrite", {31'd0, REGWRITE_OUT}, 32'd0);

        // Back-to-back stream, ending with an LUI-style operand pair.
        @(posedge CLK); #1;
        for (int unsigned k = 0; k < 5; k++) begin
            if (k < 4) begin
                drive_instr(seq[k]); VALID_IN = 1'b1;
            end else begin
                VALID_IN = 1'b0;
            end
            #2;
            if (k > 0) begin
                check($sformatf("b2b%0d_valid", k - 1), {31'd0, VALID_OUT}, 32'd1);
                check($sformatf("b2b%0d_ctrl", k - 1), {28'd0, CONTROL}, {28'd0, seq[k-1].ctrl});
                check($sformatf("b2b%0d_rd", k - 1), {27'd0, RD_OUT}, {27'd0, seq[k-1].rd});
                check($sformatf("b2b%0d_regwrite", k - 1), {31'd0, REGWRITE_OUT}, {31'd0, seq[k-1].we});
                check($sformatf("b2b%0d_x", k - 1), X, exp_x(seq[k-1]));
                check($sformatf("b2b%0d_y", k - 1), Y, exp_y(seq[k-1]));
            end
            @(posedge CLK); #1;
        end
        #2;
        check("b2b_drain_valid", {31'd0, VALID_OUT}, 32'd0);
        check("lui_x_expect", exp_x(seq[3]), 32'd0);

        // Random traffic against the reference model.
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        #1;
        RESET_N = 1'b1;
        mvalid = 1'b0;
        m = '{5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 4'd0, 5'd0, 1'b0};
        for (int unsigned n = 0; n < 500; n++) begin
            @(posedge CLK); #1;
            rnd.rs1 = 5'($urandom_range(0, 3)); rnd.rs2 = 5'($urandom_range(0, 3));
            rnd.d1 = $urandom; rnd.d2 = $urandom; rnd.imm = $urandom; rnd.pc = $urandom;
            rnd.asel = 2'($urandom_range(0, 3)); rnd.bsel = 1'($urandom_range(0, 1));
            rnd.ctrl = 4'($urandom_range(0, 15)); rnd.rd = 5'($urandom_range(0, 31));
            rnd.we = 1'($urandom_range(0, 1));
            drive_instr(rnd);
            VALID_IN = 1'($urandom_range(0, 1));
            READY_IN = ($urandom_range(0, 9) < 6);
            FLUSH = ($urandom_range(0, 11) == 0);
            EXMEM_REGWRITE = 1'($urandom_range(0, 1)); EXMEM_RD = 5'($urandom_range(0, 3));
            EXMEM_RESULT = $urandom;
            MEMWB_REGWRITE = 1'($urandom_range(0, 1)); MEMWB_RD = 5'($urandom_range(0, 3));
            MEMWB_RESULT = $urandom;
            #2;
            check("rnd_valid", {31'd0, VALID_OUT}, {31'd0, mvalid});
            check("rnd_ready", {31'd0, READY_OUT}, {31'd0, !mvalid || READY_IN});
            check("rnd_regwrite", {31'd0, REGWRITE_OUT}, {31'd0, mvalid && m.we});
            if (mvalid) begin
                check("rnd_x", X, exp_x(m));
                check("rnd_y", Y, exp_y(m));
                check("rnd_ctrl", {28'd0, CONTROL}, {28'd0, m.ctrl});
                check("rnd_rd", {27'd0, RD_OUT}, {27'd0, m.rd});
            end
            if (FLUSH) begin
                mvalid = 1'b0;
            end else if (VALID_IN && (!mvalid || READY_IN)) begin
                m = rnd;
                mvalid = 1'b1;
            end else if (READY_IN) begin
                mvalid = 1'b0;
            end else if (mvalid && MEMWB_REGWRITE) begin
                if (m.rs1 != 5'd0 && MEMWB_RD == m.rs1) m.d1 = MEMWB_RESULT;
                if (m.rs2 != 5'd0 && MEMWB_RD == m.rs2) m.d2 = MEMWB_RESULT;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
